sram_1rw_masked_scrub: RTL

//   Parametrised single-port (1RW) synchronous SRAM for the tech-cache memory macros.

---
 rtl/sram_1rw_masked_scrub_pkg.sv | 18 +
 rtl/sram_1rw_masked_scrub_if.sv | 33 +++
 rtl/sram_1rw_masked_scrub_array.sv | 36 +++
 rtl/sram_1rw_masked_scrub.sv | 111 +++++++++++
 4 files changed

// File: rtl/sram_1rw_masked_scrub_pkg.sv
// Shared types and helpers for the masked, self-scrubbing 1RW SRAM wrapper.
// The parameter-legality check is used by the top level at elaboration time.
package sram_pkg;

    typedef enum logic {
        SCRUB,
        READY
    } state_t;

    function automatic int lanes(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

    function automatic bit params_ok(input int depth, input int data_width, input int lane_width);
        return (depth >= 2) && (lane_width > 0) && (data_width % lane_width == 0);
    endfunction

endpackage

// File: rtl/sram_1rw_masked_scrub_if.sv
// Request/response and scrub-control bundle between a requester and the SRAM wrapper.
interface sram_1rw_masked_scrub_if
    import sram_pkg::*;
#(
    parameter int DEPTH      = 2048,
    parameter int DATA_WIDTH = 8,
    parameter int LANE_WIDTH = 8
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int LANES      = lanes(DATA_WIDTH, LANE_WIDTH);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [LANES-1:0]      req_wmask;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  scrub_req;
    logic                  scrub_busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask, scrub_req,
        input  req_ready, resp_valid, resp_rdata, scrub_busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask, scrub_req,
        output req_ready, resp_valid, resp_rdata, scrub_busy
    );

endinterface

// File: rtl/sram_1rw_masked_scrub_array.sv
// Raw single-port storage with per-lane write mask and a registered read port.
// Deliberately unreset: the hard macro replaces this model in synthesis.
module sram_1rw_array
    import sram_pkg::*;
#(
    parameter int DEPTH      = 2048,
    parameter int DATA_WIDTH = 8,
    parameter int LANE_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LANES      = lanes(DATA_WIDTH, LANE_WIDTH)
) (
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [LANES-1:0]      wmask,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int k = 0; k < LANES; k++) begin
                if (wmask[k]) begin
                    mem[addr][k*LANE_WIDTH +: LANE_WIDTH] <= wdata[k*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_1rw_masked_scrub.sv
// Masked 1RW SRAM wrapper: valid/ready request port, 1-cycle read response and a
// scrub engine that writes INIT_VALUE to every word after reset or on request.
module sram_1rw_masked_scrub
    import sram_pkg::*;
#(
    parameter int                    DEPTH      = 2048,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    LANE_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input logic                    clock,
    input logic                    reset,
    sram_1rw_masked_scrub_if.slave bus
);

    localparam int                    ADDR_WIDTH = $clog2(DEPTH);
    localparam int                    LANES      = lanes(DATA_WIDTH, LANE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH + 1)'(DEPTH);

    if (!params_ok(DEPTH, DATA_WIDTH, LANE_WIDTH)) begin : g_bad_params
        $error("sram_1rw_masked_scrub: DEPTH must be >= 2 and DATA_WIDTH a multiple of LANE_WIDTH");
    end

    state_t                state;
    logic [ADDR_WIDTH-1:0] scrub_ptr;
    logic                  resp_valid_q;
    logic                  rdata_zero_q;
    logic                  accept;
    logic                  in_range;

    logic [ADDR_WIDTH-1:0] arr_addr;
    logic                  arr_we;
    logic                  arr_re;
    logic [LANES-1:0]      arr_wmask;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign bus.req_ready  = (state == READY) && !bus.scrub_req;
    assign bus.scrub_busy = (state == SCRUB);
    assign accept         = bus.req_valid && bus.req_ready;
    assign in_range       = {1'b0, bus.req_addr} < DEPTH_EXT;

    // The scrub engine owns the array port outright while scrubbing.
    always_comb begin
        arr_addr  = bus.req_addr;
        arr_we    = accept && bus.req_write && in_range;
        arr_re    = accept && !bus.req_write && in_range && !reset;
        arr_wmask = bus.req_wmask;
        arr_wdata = bus.req_wdata;
        if (state == SCRUB) begin
            arr_addr  = scrub_ptr;
            arr_we    = 1'b1;
            arr_re    = 1'b0;
            arr_wmask = '1;
            arr_wdata = INIT_VALUE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= SCRUB;
            scrub_ptr    <= '0;
            resp_valid_q <= 1'b0;
            rdata_zero_q <= 1'b1;
        end else begin
            case (state)
                SCRUB: begin
                    if (scrub_ptr == LAST_ADDR) begin
                        state     <= READY;
                        scrub_ptr <= '0;
                    end else begin
                        scrub_ptr <= scrub_ptr + 1'b1;
                    end
                end
                READY: begin
                    if (bus.scrub_req) begin
                        state     <= SCRUB;
                        scrub_ptr <= '0;
                    end
                end
                default: state <= SCRUB;
            endcase
            resp_valid_q <= accept && !bus.req_write;
            // Out-of-range reads answer zero; the array's own rdata keeps the last real word.
            if (accept && !bus.req_write) begin
                rdata_zero_q <= !in_range;
            end
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_zero_q ? '0 : arr_rdata;

    sram_1rw_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_WIDTH (LANE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANES      (LANES)
    ) u_array (
        .clock (clock),
        .addr  (arr_addr),
        .we    (arr_we),
        .wmask (arr_wmask),
        .wdata (arr_wdata),
        .re    (arr_re),
        .rdata (arr_rdata)
    );

endmodule
